arcade_input_ctrl: RTL and testbench

ARCADE_INPUT_CTRL -- requirements
Module: arcade_input_ctrl

---
 rtl/arcade_input_pkg.sv | 99 +++++++++
 rtl/coin_pulse_gen.sv | 64 ++++++
 rtl/arcade_input_ctrl.sv | 103 ++++++++++
 tb/tb_arcade_input_ctrl.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/arcade_input_pkg.sv
// Shared definitions for the arcade input controller.
// - PS/2 set-2 scancodes used by the keyboard map (9-bit {ext, code}, arrows 8-bit).
// - Joystick bit positions shared by both joystick inputs and the 5-bit player outputs.
// - Internal key-flop indices plus a one-hot decoder from scancode to key flop.
// - Coin FSM state type.
package arcade_input_pkg;

    // Arrow keys are matched on the low 8 bits only, so the keypad variants alias them.
    localparam logic [7:0] ScArrowUp    = 8'h75;
    localparam logic [7:0] ScArrowDown  = 8'h72;
    localparam logic [7:0] ScArrowLeft  = 8'h6B;
    localparam logic [7:0] ScArrowRight = 8'h74;

    localparam logic [8:0] ScSpace = 9'h029;
    localparam logic [8:0] ScLCtrl = 9'h014;
    localparam logic [8:0] ScF1    = 9'h005;
    localparam logic [8:0] ScF2    = 9'h006;
    localparam logic [8:0] ScR     = 9'h02D;
    localparam logic [8:0] ScF     = 9'h02B;
    localparam logic [8:0] ScD     = 9'h023;
    localparam logic [8:0] ScG     = 9'h034;
    localparam logic [8:0] ScA     = 9'h01C;
    localparam logic [8:0] Sc1     = 9'h016;
    localparam logic [8:0] Sc2     = 9'h01E;
    localparam logic [8:0] Sc5     = 9'h02E;
    localparam logic [8:0] Sc6     = 9'h036;
    localparam logic [8:0] ScT     = 9'h02C;

    // Joystick bit positions; the player outputs use the same order for bits [4:0].
    localparam int unsigned JoyRight  = 0;
    localparam int unsigned JoyLeft   = 1;
    localparam int unsigned JoyDown   = 2;
    localparam int unsigned JoyUp     = 3;
    localparam int unsigned JoyFire   = 4;
    localparam int unsigned JoyStart1 = 5;
    localparam int unsigned JoyStart2 = 6;
    localparam int unsigned JoyCoin   = 7;

    // One flop per physical key, so two keys sharing a function release independently.
    localparam int unsigned KeyP1Up     = 0;
    localparam int unsigned KeyP1Down   = 1;
    localparam int unsigned KeyP1Left   = 2;
    localparam int unsigned KeyP1Right  = 3;
    localparam int unsigned KeyP1FireA  = 4;
    localparam int unsigned KeyP1FireB  = 5;
    localparam int unsigned KeyF1Start1 = 6;
    localparam int unsigned KeyF2Start2 = 7;
    localparam int unsigned KeyP2Up     = 8;
    localparam int unsigned KeyP2Down   = 9;
    localparam int unsigned KeyP2Left   = 10;
    localparam int unsigned KeyP2Right  = 11;
    localparam int unsigned KeyP2Fire   = 12;
    localparam int unsigned Key1Start1  = 13;
    localparam int unsigned Key2Start2  = 14;
    localparam int unsigned KeyCoin5    = 15;
    localparam int unsigned KeyCoin6    = 16;
    localparam int unsigned KeyTest     = 17;
    localparam int unsigned NumKeys     = 18;

    typedef enum logic [1:0] {CoinIdle, CoinPulse, CoinHold} coin_state_t;

    // One-hot key select for a {ext, code} scancode; all-zero for unlisted codes.
    function automatic logic [NumKeys-1:0] key_decode(input logic [8:0] sc);
        logic [NumKeys-1:0] hit;
        hit = '0;
        case (sc[7:0])
            ScArrowUp:    hit[KeyP1Up]    = 1'b1;
            ScArrowDown:  hit[KeyP1Down]  = 1'b1;
            ScArrowLeft:  hit[KeyP1Left]  = 1'b1;
            ScArrowRight: hit[KeyP1Right] = 1'b1;
            default: ;
        endcase
        case (sc)
            ScSpace: hit[KeyP1FireA]  = 1'b1;
            ScLCtrl: hit[KeyP1FireB]  = 1'b1;
            ScF1:    hit[KeyF1Start1] = 1'b1;
            ScF2:    hit[KeyF2Start2] = 1'b1;
            ScR:     hit[KeyP2Up]     = 1'b1;
            ScF:     hit[KeyP2Down]   = 1'b1;
            ScD:     hit[KeyP2Left]   = 1'b1;
            ScG:     hit[KeyP2Right]  = 1'b1;
            ScA:     hit[KeyP2Fire]   = 1'b1;
            Sc1:     hit[Key1Start1]  = 1'b1;
            Sc2:     hit[Key2Start2]  = 1'b1;
            Sc5:     hit[KeyCoin5]    = 1'b1;
            Sc6:     hit[KeyCoin6]    = 1'b1;
            ScT:     hit[KeyTest]     = 1'b1;
            default: ;
        endcase
        return hit;
    endfunction

    // Horizontal-cabinet remap of {fire, up, down, left, right}:
    // up<-left, down<-right, left<-down, right<-up.
    function automatic logic [4:0] rotate_dirs(input logic [4:0] d, input logic en);
        return en ? {d[JoyFire], d[JoyLeft], d[JoyRight], d[JoyDown], d[JoyUp]} : d;
    endfunction

endpackage

// File: rtl/coin_pulse_gen.sv
// Coin pulse generator: one fixed-length pulse per assertion of req.
// Ports:
//   clk_sys - system clock (rising edge)
//   reset   - synchronous active-high reset
//   req     - coin request level
//   pulse   - registered coin pulse, COIN_PULSE_CYC cycles long
module coin_pulse_gen
    import arcade_input_pkg::*;
#(
    parameter int unsigned COIN_PULSE_CYC = 600000
) (
    input  logic clk_sys,
    input  logic reset,
    input  logic req,
    output logic pulse
);

    localparam int unsigned CntW = $clog2(COIN_PULSE_CYC + 1);
    localparam logic [CntW-1:0] CntLoad = CntW'(COIN_PULSE_CYC - 1);

    coin_state_t     state_q;
    logic [CntW-1:0] cnt_q;
    logic            pulse_q;

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state_q <= CoinIdle;
            cnt_q   <= '0;
            pulse_q <= 1'b0;
        end else begin
            unique case (state_q)
                CoinIdle: begin
                    if (req) begin
                        state_q <= CoinPulse;
                        cnt_q   <= CntLoad;
                        pulse_q <= 1'b1;
                    end
                end
                CoinPulse: begin
                    // req is deliberately ignored until the count expires.
                    if (cnt_q == '0) begin
                        pulse_q <= 1'b0;
                        state_q <= req ? CoinHold : CoinIdle;
                    end else begin
                        cnt_q <= cnt_q - CntW'(1);
                    end
                end
                CoinHold: begin
                    // Wait for release so a held button yields a single pulse.
                    if (!req) begin
                        state_q <= CoinIdle;
                    end
                end
                default: begin
                    state_q <= CoinIdle;
                    pulse_q <= 1'b0;
                end
            endcase
        end
    end

    assign pulse = pulse_q;

endmodule

// File: rtl/arcade_input_ctrl.sv
// Arcade input controller: merges PS/2 keyboard events and two joysticks into
// player direction/fire buttons, start, coin and test signals.
// Ports:
//   clk_sys               - system clock (rising edge)
//   reset                 - synchronous active-high reset
//   ps2_key[10:0]         - {toggle, pressed, ext, scancode}; a toggle change is one event
//   joystick_0/1[15:0]    - [0] right [1] left [2] down [3] up [4] fire [5] st1 [6] st2 [7] coin
//   rotate                - remap directions for a horizontal-orientation screen
//   o_p1/o_p2[4:0]        - {fire, up, down, left, right}, registered
//   o_start1/2, o_coin, o_test - registered, active-high
module arcade_input_ctrl
    import arcade_input_pkg::*;
#(
    parameter int unsigned COIN_PULSE_CYC = 600000,
    parameter bit          AUTO_COIN      = 1'b1
) (
    input  logic        clk_sys,
    input  logic        reset,
    input  logic [10:0] ps2_key,
    input  logic [15:0] joystick_0,
    input  logic [15:0] joystick_1,
    input  logic        rotate,
    output logic [4:0]  o_p1,
    output logic [4:0]  o_p2,
    output logic        o_start1,
    output logic        o_start2,
    output logic        o_coin,
    output logic        o_test
);

    logic               toggle_q;
    logic               key_event;
    logic [NumKeys-1:0] key_hit;
    logic [NumKeys-1:0] key_q, key_d;

    logic [4:0] p1_raw, p2_raw;
    logic       start1_raw, start2_raw, coin_req;

    logic [4:0] p1_q, p2_q;
    logic       start1_q, start2_q, test_q;

    logic       unused_joy;
    assign unused_joy = ^{joystick_0[15:8], joystick_1[15:8]};

    always_comb begin
        key_event = ps2_key[10] ^ toggle_q;
        key_hit   = key_decode(ps2_key[8:0]);
        key_d     = key_q;
        if (key_event) begin
            key_d = (key_q & ~key_hit) | (key_hit & {NumKeys{ps2_key[9]}});
        end
    end

    always_comb begin
        p1_raw = {key_q[KeyP1FireA] | key_q[KeyP1FireB], key_q[KeyP1Up], key_q[KeyP1Down],
                  key_q[KeyP1Left], key_q[KeyP1Right]} | joystick_0[4:0];
        p2_raw = {key_q[KeyP2Fire], key_q[KeyP2Up], key_q[KeyP2Down],
                  key_q[KeyP2Left], key_q[KeyP2Right]} | joystick_1[4:0];
        start1_raw = key_q[KeyF1Start1] | key_q[Key1Start1]
                   | joystick_0[JoyStart1] | joystick_1[JoyStart1];
        start2_raw = key_q[KeyF2Start2] | key_q[Key2Start2]
                   | joystick_0[JoyStart2] | joystick_1[JoyStart2];
        coin_req   = key_q[KeyCoin5] | key_q[KeyCoin6]
                   | joystick_0[JoyCoin] | joystick_1[JoyCoin]
                   | (AUTO_COIN & (start1_raw | start2_raw));
    end

    always_ff @(posedge clk_sys) begin
        // Tracking the toggle through reset avoids a phantom event on release.
        toggle_q <= ps2_key[10];
        if (reset) begin
            key_q    <= '0;
            p1_q     <= '0;
            p2_q     <= '0;
            start1_q <= 1'b0;
            start2_q <= 1'b0;
            test_q   <= 1'b0;
        end else begin
            key_q    <= key_d;
            p1_q     <= rotate_dirs(p1_raw, rotate);
            p2_q     <= rotate_dirs(p2_raw, rotate);
            start1_q <= start1_raw;
            start2_q <= start2_raw;
            test_q   <= key_q[KeyTest];
        end
    end

    coin_pulse_gen #(
        .COIN_PULSE_CYC(COIN_PULSE_CYC)
    ) u_coin_pulse_gen (
        .clk_sys(clk_sys),
        .reset  (reset),
        .req    (coin_req),
        .pulse  (o_coin)
    );

    assign o_p1     = p1_q;
    assign o_p2     = p2_q;
    assign o_start1 = start1_q;
    assign o_start2 = start2_q;
    assign o_test   = test_q;

endmodule

// File: tb/tb_arcade_input_ctrl.sv
// Directed bench for arcade_input_ctrl with an 8-cycle coin pulse.
module tb_arcade_input_ctrl;

    logic        clk_sys;
    logic        reset;
    logic [10:0] ps2_key;
    logic [15:0] joystick_0;
    logic [15:0] joystick_1;
    logic        rotate;
    logic [4:0]  o_p1;
    logic [4:0]  o_p2;
    logic        o_start1;
    logic        o_start2;
    logic        o_coin;
    logic        o_test;

    logic        ps2_tog;
    int          vectors;
    int          miscompares;

    arcade_input_ctrl #(
        .COIN_PULSE_CYC(8),
        .AUTO_COIN     (1'b1)
    ) dut (
        .clk_sys   (clk_sys),
        .reset     (reset),
        .ps2_key   (ps2_key),
        .joystick_0(joystick_0),
        .joystick_1(joystick_1),
        .rotate    (rotate),
        .o_p1      (o_p1),
        .o_p2      (o_p2),
        .o_start1  (o_start1),
        .o_start2  (o_start2),
        .o_coin    (o_coin),
        .o_test    (o_test)
    );

    initial clk_sys = 1'b0;
    always #5 clk_sys = ~clk_sys;

    task automatic tick(input int n);
        repeat (n) @(posedge clk_sys);
        #1;
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send_key(input logic pressed, input logic [8:0] sc);
        ps2_tog = ~ps2_tog;
        ps2_key = {ps2_tog, pressed, sc};
    endtask

    task automatic count_coin(input int cycles, output int highs, output int rises);
        logic prev;
        prev  = o_coin;
        highs = 0;
        rises = 0;
        for (int i = 0; i < cycles; i++) begin
            tick(1);
            if (o_coin) highs++;
            if (o_coin && !prev) rises++;
            prev = o_coin;
        end
    endtask

    int h1, r1, h2, r2;

    initial begin
        vectors     = 0;
        miscompares = 0;
        ps2_tog     = 1'b0;
        ps2_key     = '0;
        joystick_0  = '0;
        joystick_1  = '0;
        rotate      = 1'b0;
        reset       = 1'b1;
        tick(3);
        check("rst_p1", 16'(o_p1), 16'h0);
        check("rst_p2", 16'(o_p2), 16'h0);
        check("rst_coin", 16'(o_coin), 16'h0);
        check("rst_start", 16'({o_start1, o_start2}), 16'h0);
        check("rst_test", 16'(o_test), 16'h0);
        reset = 1'b0;
        tick(1);

        // Arrow up press/release: two-cycle latency.
        send_key(1'b1, 9'h075);
        tick(1);
        check("up_lat1", 16'(o_p1), 16'h00);
        tick(1);
        check("up_press", 16'(o_p1), 16'h08);
        send_key(1'b0, 9'h075);
        tick(1);
        check("up_rel_lat1", 16'(o_p1), 16'h08);
        tick(1);
        check("up_release", 16'(o_p1), 16'h00);

        // Extended arrow left still maps (ext ignored for arrows).
        send_key(1'b1, 9'h16B);
        tick(2);
        check("ext_left", 16'(o_p1), 16'h02);
        send_key(1'b0, 9'h16B);
        tick(2);
        check("ext_left_rel", 16'(o_p1), 16'h00);

        // Rotate remap on joystick paths, one-cycle latency.
        rotate     = 1'b1;
        joystick_0 = 16'h0002;
        tick(1);
        check("rot_left_up", 16'(o_p1), 16'h08);
        joystick_1 = 16'h001F;
        tick(1);
        check("rot_p1_indep", 16'(o_p1), 16'h08);
        check("rot_p2_all", 16'(o_p2), 16'h1F);
        joystick_1 = 16'h0001;
        tick(1);
        check("rot_right_down", 16'(o_p2), 16'h04);
        joystick_0 = 16'h0010;
        joystick_1 = 16'h0000;
        tick(1);
        check("rot_fire", 16'(o_p1), 16'h10);
        rotate     = 1'b0;
        joystick_0 = 16'h0008;
        tick(1);
        check("norot_up", 16'(o_p1), 16'h08);
        joystick_0 = '0;
        tick(2);

        // Coin key held 10 cycles: one 8-cycle pulse, then held low.
        send_key(1'b1, 9'h02E);
        count_coin(10, h1, r1);
        send_key(1'b0, 9'h02E);
        count_coin(5, h2, r2);
        check("coin5_high", 16'(h1 + h2), 16'd8);
        check("coin5_rises", 16'(r1 + r2), 16'd1);
        check("coin5_end", 16'(o_coin), 16'h0);

        // Re-press gives a second pulse.
        send_key(1'b1, 9'h02E);
        count_coin(10, h1, r1);
        send_key(1'b0, 9'h02E);
        count_coin(5, h2, r2);
        check("coin5b_high", 16'(h1 + h2), 16'd8);
        check("coin5b_rises", 16'(r1 + r2), 16'd1);

        // Short press: pulse still runs its full length.
        send_key(1'b1, 9'h036);
        count_coin(2, h1, r1);
        send_key(1'b0, 9'h036);
        count_coin(12, h2, r2);
        check("coin_short_high", 16'(h1 + h2), 16'd8);
        check("coin_short_rises", 16'(r1 + r2), 16'd1);

        // Joystick start held 100 cycles: auto coin, single pulse.
        joystick_0 = 16'h0020;
        count_coin(100, h1, r1);
        check("start1_hold", 16'(o_start1), 16'h1);
        check("start1_coin_high", 16'(h1), 16'd8);
        check("start1_coin_rises", 16'(r1), 16'd1);
        check("start1_no_dir", 16'(o_p1), 16'h00);
        joystick_0 = '0;
        tick(3);
        check("start1_rel", 16'(o_start1), 16'h0);
        check("start1_coin_rel", 16'(o_coin), 16'h0);

        // Back-to-back events on consecutive cycles.
        send_key(1'b1, 9'h075);
        tick(1);
        send_key(1'b1, 9'h06B);
        tick(1);
        send_key(1'b1, 9'h029);
        tick(2);
        check("b2b_p1", 16'(o_p1), 16'h1A);
        send_key(1'b1, 9'h0AA);
        tick(2);
        check("unlisted_p1", 16'(o_p1), 16'h1A);
        check("unlisted_p2", 16'(o_p2), 16'h00);
        check("unlisted_misc", 16'({o_start1, o_start2, o_coin, o_test}), 16'h0);
        send_key(1'b1, 9'h02C);
        tick(1);
        send_key(1'b1, 9'h02D);
        tick(2);
        check("test_key", 16'(o_test), 16'h1);
        check("p2_up_key", 16'(o_p2), 16'h08);
        send_key(1'b0, 9'h029);
        tick(2);
        check("fire_rel", 16'(o_p1), 16'h0A);
        send_key(1'b0, 9'h075);
        tick(1);
        send_key(1'b0, 9'h06B);
        tick(1);
        send_key(1'b0, 9'h02C);
        tick(1);
        send_key(1'b0, 9'h02D);
        tick(2);
        check("all_rel", 16'({o_p1, o_p2, o_test}), 16'h0);

        // Reset in the 4th pulse cycle with a pending toggle change.
        send_key(1'b1, 9'h036);
        tick(5);
        check("pulse_c4", 16'(o_coin), 16'h1);
        reset = 1'b1;
        send_key(1'b1, 9'h075);
        tick(1);
        check("rst_drop_coin", 16'(o_coin), 16'h0);
        joystick_1 = 16'h0080;
        tick(2);
        check("rst_hold_coin", 16'(o_coin), 16'h0);
        reset = 1'b0;
        tick(1);
        check("post_rst_pulse", 16'(o_coin), 16'h1);
        check("post_rst_p1_a", 16'(o_p1), 16'h00);
        tick(1);
        check("post_rst_p1_b", 16'(o_p1), 16'h00);
        joystick_1 = '0;
        count_coin(12, h1, r1);
        check("post_rst_high", 16'(h1), 16'd6);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
